// File: rtl/event_buf_ctrl_pkg.sv
// Shared types and geometry for the event buffer controller and global_event_buf.
// Sensor geometry, event field layout and FSM state encoding live here.
package event_buf_ctrl_pkg;

  localparam int WIDTH     = 120;
  localparam int HEIGHT    = 100;
  localparam int TOT_PIXEL = WIDTH * HEIGHT;
  localparam int IDX_W     = $clog2(TOT_PIXEL);

  // Bit positions of the fields inside the 64-bit sensor event word.
  localparam int EV_X_LSB   = 0;
  localparam int EV_Y_LSB   = 8;
  localparam int EV_COORD_W = 8;
  localparam int EV_POL_BIT = 16;
  localparam int EV_T_LSB   = 32;

  typedef struct packed {
    logic [31:0] t;
    logic [14:0] rsvd;
    logic        pol;
    logic [7:0]  y;
    logic [7:0]  x;
  } event_s;

  typedef logic [IDX_W-1:0] pixel_idx_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_READ,
    ST_HOLD,
    ST_WRITE
  } state_e;

endpackage

// File: rtl/event_buf_ctrl_if.sv
// Bundle between the event sequencer and its neighbours: sensor stream in,
// buffer control out, history strobe to the graph stage.
interface event_buf_ctrl_if #(
  parameter int IDX_BITS = event_buf_ctrl_pkg::IDX_W
);
  import event_buf_ctrl_pkg::*;

  logic                ev_valid;
  logic                ev_ready;
  event_s              ev_data;
  logic [IDX_BITS-1:0] buf_pixel_idx;
  logic                buf_en;
  logic                buf_wr_rdn;
  logic [63:0]         buf_din;
  logic                hist_valid;
  logic                hist_ready;
  event_s              hist_event;
  logic [IDX_BITS-1:0] hist_pixel_idx;
  logic                init_done;
  logic [15:0]         drop_cnt;

  modport master (
    input  ev_valid, ev_data, hist_ready,
    output ev_ready, buf_pixel_idx, buf_en, buf_wr_rdn, buf_din,
           hist_valid, hist_event, hist_pixel_idx, init_done, drop_cnt
  );

  modport slave (
    output ev_valid, ev_data, hist_ready,
    input  ev_ready, buf_pixel_idx, buf_en, buf_wr_rdn, buf_din,
           hist_valid, hist_event, hist_pixel_idx, init_done, drop_cnt
  );

endinterface

// File: rtl/event_buf_ctrl_decode.sv
// event_decode: range-checks an event's coordinates and maps them to a
// row-major pixel index; the index is forced to zero for out-of-range events.
module event_decode #(
  parameter int WIDTH  = event_buf_ctrl_pkg::WIDTH,
  parameter int HEIGHT = event_buf_ctrl_pkg::HEIGHT,
  parameter int IDX_W  = $clog2(WIDTH * HEIGHT)
) (
  input  logic [7:0]       x_i,
  input  logic [7:0]       y_i,
  output logic             in_range_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [IDX_W-1:0] WIDTH_C = IDX_W'(WIDTH);

  always_comb begin
    in_range_o = ({24'd0, x_i} < 32'(WIDTH)) && ({24'd0, y_i} < 32'(HEIGHT));
    // Constant multiply; only in-range coordinates reach it, so no wrap.
    idx_o = in_range_o ? (IDX_W'(y_i) * WIDTH_C + IDX_W'(x_i)) : '0;
  end

endmodule

// File: rtl/event_buf_ctrl.sv
// Sequencer in front of global_event_buf: zero-sweeps the buffer after reset,
// then runs each accepted event through read, present-history and write.
module event_buf_ctrl #(
  parameter int WIDTH  = event_buf_ctrl_pkg::WIDTH,
  parameter int HEIGHT = event_buf_ctrl_pkg::HEIGHT,
  parameter int IDX_W  = $clog2(WIDTH * HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  event_buf_ctrl_if.master bus
);
  import event_buf_ctrl_pkg::*;

  localparam int               TOT      = WIDTH * HEIGHT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOT - 1);

  state_e           state_q;
  logic [IDX_W-1:0] clr_cnt_q;
  logic             clr_done_q;
  event_s           cur_ev_q;
  logic [IDX_W-1:0] cur_idx_q;

  logic             ev_ready_q;
  logic             buf_en_q;
  logic             buf_wr_rdn_q;
  logic [63:0]      buf_din_q;
  logic [IDX_W-1:0] buf_idx_q;
  logic             hist_valid_q;
  event_s           hist_event_q;
  logic [IDX_W-1:0] hist_idx_q;
  logic             init_done_q;
  logic [15:0]      drop_cnt_q;
  logic [15:0]      drop_cnt_d;

  logic             dec_in_range;
  logic [IDX_W-1:0] dec_idx;

  event_decode #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .IDX_W  (IDX_W)
  ) u_decode (
    .x_i        (bus.ev_data[EV_X_LSB +: EV_COORD_W]),
    .y_i        (bus.ev_data[EV_Y_LSB +: EV_COORD_W]),
    .in_range_o (dec_in_range),
    .idx_o      (dec_idx)
  );

  always_comb begin
    drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
  end

  // Outputs are registered alongside the state so each one reflects the
  // state being entered, never a combinational decode of ev_valid/hist_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      clr_done_q   <= 1'b0;
      cur_ev_q     <= '0;
      cur_idx_q    <= '0;
      ev_ready_q   <= 1'b0;
      buf_en_q     <= 1'b0;
      buf_wr_rdn_q <= 1'b0;
      buf_din_q    <= '0;
      buf_idx_q    <= '0;
      hist_valid_q <= 1'b0;
      hist_event_q <= '0;
      hist_idx_q   <= '0;
      init_done_q  <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (!clr_done_q) begin
            buf_en_q     <= 1'b1;
            buf_wr_rdn_q <= 1'b1;
            buf_din_q    <= '0;
            buf_idx_q    <= clr_cnt_q;
            if (clr_cnt_q == LAST_IDX) begin
              clr_done_q <= 1'b1;
            end else begin
              clr_cnt_q <= clr_cnt_q + 1'b1;
            end
          end else begin
            buf_en_q     <= 1'b0;
            buf_wr_rdn_q <= 1'b0;
            init_done_q  <= 1'b1;
            ev_ready_q   <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (bus.ev_valid && ev_ready_q) begin
            if (!dec_in_range) begin
              drop_cnt_q <= drop_cnt_d;
            end else begin
              cur_ev_q     <= bus.ev_data;
              cur_idx_q    <= dec_idx;
              ev_ready_q   <= 1'b0;
              buf_en_q     <= 1'b1;
              buf_wr_rdn_q <= 1'b0;
              buf_idx_q    <= dec_idx;
              buf_din_q    <= bus.ev_data;
              state_q      <= ST_READ;
            end
          end
        end

        ST_READ: begin
          buf_en_q     <= 1'b0;
          hist_valid_q <= 1'b1;
          hist_event_q <= cur_ev_q;
          hist_idx_q   <= cur_idx_q;
          state_q      <= ST_HOLD;
        end

        // buf_din keeps cur_ev throughout, as the buffer samples din every cycle.
        ST_HOLD: begin
          if (bus.hist_ready) begin
            hist_valid_q <= 1'b0;
            buf_en_q     <= 1'b1;
            buf_wr_rdn_q <= 1'b1;
            buf_idx_q    <= cur_idx_q;
            state_q      <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          buf_en_q     <= 1'b0;
          buf_wr_rdn_q <= 1'b0;
          buf_din_q    <= '0;
          ev_ready_q   <= 1'b1;
          state_q      <= ST_IDLE;
        end

        default: begin
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

  assign bus.ev_ready       = ev_ready_q;
  assign bus.buf_en         = buf_en_q;
  assign bus.buf_wr_rdn     = buf_wr_rdn_q;
  assign bus.buf_din        = buf_din_q;
  assign bus.buf_pixel_idx  = buf_idx_q;
  assign bus.hist_valid     = hist_valid_q;
  assign bus.hist_event     = hist_event_q;
  assign bus.hist_pixel_idx = hist_idx_q;
  assign bus.init_done      = init_done_q;
  assign bus.drop_cnt       = drop_cnt_q;

endmodule
